// File: rtl/wbu.sv
// Write-back unit: one-entry register stage that merges EXU and LSU completions into the GPR
// write port and retire stream. Define WBU_INSTRET_EN to build the retired-instruction counter.
`ifndef XLEN
`define XLEN 64
`endif

module wbu (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              exu_ready,
    input  logic [4:0]        exu_rd,
    input  logic              exu_rd_w_en,
    input  logic [`XLEN-1:0]  exu_res,
    input  logic [`XLEN-1:0]  exu_pc,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [4:0]        lsu_rd,
    input  logic              lsu_rd_w_en,
    input  logic [`XLEN-1:0]  lsu_rdata,
    input  logic [2:0]        lsu_funct3,
    input  logic [2:0]        lsu_addr_lo,
    input  logic [`XLEN-1:0]  lsu_pc,
    output logic [4:0]        rd,
    output logic              rd_w_en,
    output logic [`XLEN-1:0]  x_rd,
    output logic              commit_valid,
    output logic [`XLEN-1:0]  commit_pc,
    output logic [63:0]       instret
);

    typedef enum logic [0:0] {StIdle, StWb} state_e;

    state_e            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              wen_q, wen_d;
    logic [`XLEN-1:0]  x_q, x_d;
    logic [`XLEN-1:0]  pc_q, pc_d;

    logic              acc_lsu, acc_exu;
    logic [5:0]        b_idx, h_idx, w_idx;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [31:0]       ld_w;
    logic [`XLEN-1:0]  ld_data;

    // Readies follow the reset pin so nothing is accepted while reset is held.
    assign lsu_ready = rst;
    assign exu_ready = rst & ~lsu_valid;
    assign acc_lsu   = lsu_valid & lsu_ready;
    assign acc_exu   = exu_valid & exu_ready;

    assign b_idx = {lsu_addr_lo, 3'b000};
    assign h_idx = {lsu_addr_lo[2:1], 4'b0000};
    assign w_idx = {lsu_addr_lo[2], 5'b00000};
    assign ld_b  = lsu_rdata[b_idx +: 8];
    assign ld_h  = lsu_rdata[h_idx +: 16];
    assign ld_w  = lsu_rdata[w_idx +: 32];

    always_comb begin
        ld_data = '0;
        unique case (lsu_funct3)
            3'b000:  ld_data = {{(`XLEN-8){ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{(`XLEN-16){ld_h[15]}}, ld_h};
            3'b010:  ld_data = {{(`XLEN-32){ld_w[31]}}, ld_w};
            3'b011:  ld_data = lsu_rdata;
            3'b100:  ld_data = {{(`XLEN-8){1'b0}}, ld_b};
            3'b101:  ld_data = {{(`XLEN-16){1'b0}}, ld_h};
            3'b110:  ld_data = {{(`XLEN-32){1'b0}}, ld_w};
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_d = StIdle;
        rd_d    = '0;
        wen_d   = 1'b0;
        x_d     = '0;
        pc_d    = '0;
        if (acc_lsu) begin
            state_d = StWb;
            rd_d    = lsu_rd;
            wen_d   = lsu_rd_w_en & (lsu_rd != 5'd0);
            x_d     = ld_data;
            pc_d    = lsu_pc;
        end else if (acc_exu) begin
            state_d = StWb;
            rd_d    = exu_rd;
            wen_d   = exu_rd_w_en & (exu_rd != 5'd0);
            x_d     = exu_res;
            pc_d    = exu_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            x_q     <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            x_q     <= x_d;
            pc_q    <= pc_d;
        end
    end

    assign commit_valid = (state_q == StWb);
    assign rd           = rd_q;
    assign rd_w_en      = wen_q;
    assign x_rd         = x_q;
    assign commit_pc    = pc_q;

`ifdef WBU_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (state_q == StWb) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wbu.sv
// Directed self-checking bench for wbu: reset values, EXU/LSU write-back, load extraction,
// arbitration, rd=0/store handling, asynchronous reset discard and instret.
`timescale 1ns/1ps

module tb_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, exu_ready, exu_rd_w_en;
    logic [4:0]  exu_rd;
    logic [63:0] exu_res, exu_pc;
    logic        lsu_valid, lsu_ready, lsu_rd_w_en;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_rdata, lsu_pc;
    logic [2:0]  lsu_funct3, lsu_addr_lo;
    logic [4:0]  rd;
    logic        rd_w_en, commit_valid;
    logic [63:0] x_rd, commit_pc, instret;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [63:0] exp_cnt;

    localparam logic [63:0] RData = 64'h80FF_7F01_8002_00F0;

    wbu u_dut (
        .clk          (clk),
        .rst          (rst),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_rd_w_en  (exu_rd_w_en),
        .exu_res      (exu_res),
        .exu_pc       (exu_pc),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_rd_w_en  (lsu_rd_w_en),
        .lsu_rdata    (lsu_rdata),
        .lsu_funct3   (lsu_funct3),
        .lsu_addr_lo  (lsu_addr_lo),
        .lsu_pc       (lsu_pc),
        .rd           (rd),
        .rd_w_en      (rd_w_en),
        .x_rd         (x_rd),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        exu_valid = 0; exu_rd = 0; exu_rd_w_en = 0; exu_res = 0; exu_pc = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_rd_w_en = 0; lsu_rdata = 0;
        lsu_funct3 = 0; lsu_addr_lo = 0; lsu_pc = 0;
    endtask

    task automatic drive_exu(input logic [4:0] r, input logic w, input logic [63:0] res,
                             input logic [63:0] pc);
        exu_valid = 1; exu_rd = r; exu_rd_w_en = w; exu_res = res; exu_pc = pc;
    endtask

    task automatic drive_lsu(input logic [4:0] r, input logic w, input logic [2:0] f3,
                             input logic [2:0] lo, input logic [63:0] pc);
        lsu_valid = 1; lsu_rd = r; lsu_rd_w_en = w; lsu_rdata = RData;
        lsu_funct3 = f3; lsu_addr_lo = lo; lsu_pc = pc;
    endtask

    // One load through the stage, checking the extracted value the next cycle.
    task automatic load_case(input string tag, input logic [2:0] f3, input logic [2:0] lo,
                             input logic [63:0] exp);
        drive_lsu(5'd10, 1'b1, f3, lo, 64'h1000);
        tick();
        check(tag, x_rd, exp);
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        #3;
        check("rst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        check("rst_exu_ready", {63'd0, exu_ready}, 64'd0);
        check("rst_commit", {63'd0, commit_valid}, 64'd0);
        check("rst_wen", {63'd0, rd_w_en}, 64'd0);
        check("rst_x_rd", x_rd, 64'd0);
        check("rst_instret", instret, 64'd0);

        @(negedge clk);
        rst = 1;
        drive_exu(5'd5, 1'b1, 64'h1234, 64'h8000_0000);
        #1;
        check("lsu_ready_out_of_rst", {63'd0, lsu_ready}, 64'd1);
        check("exu_ready_idle", {63'd0, exu_ready}, 64'd1);
        tick();
        check("exu_wen", {63'd0, rd_w_en}, 64'd1);
        check("exu_rd", {59'd0, rd}, 64'd5);
        check("exu_x_rd", x_rd, 64'h1234);
        check("exu_pc", commit_pc, 64'h8000_0000);
        check("exu_commit", {63'd0, commit_valid}, 64'd1);

        exu_valid = 0;
        drive_lsu(5'd10, 1'b1, 3'b000, 3'd7, 64'h1000);
        #1;
        check("exu_ready_lsu_prio", {63'd0, exu_ready}, 64'd0);
        tick();
        check("lb_7", x_rd, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_wen", {63'd0, rd_w_en}, 64'd1);
        check("lb_pc", commit_pc, 64'h1000);
        load_case("lhu_2", 3'b101, 3'd2, 64'h8002);
        load_case("lw_4", 3'b010, 3'd4, 64'hFFFF_FFFF_80FF_7F01);
        load_case("ld", 3'b011, 3'd0, RData);
        load_case("f3_111", 3'b111, 3'd0, 64'd0);
        load_case("lbu_0", 3'b100, 3'd0, 64'hF0);
        load_case("lh_6", 3'b001, 3'd6, 64'hFFFF_FFFF_FFFF_80FF);
        load_case("lwu_1", 3'b110, 3'd1, 64'h8002_00F0);
        load_case("lb_5", 3'b000, 3'd5, 64'h7F);

        // Simultaneous completions: LSU first, EXU held and taken next cycle.
        drive_exu(5'd3, 1'b1, 64'h33, 64'h2000);
        drive_lsu(5'd4, 1'b1, 3'b011, 3'd0, 64'h3000);
        #1;
        check("sim_exu_ready", {63'd0, exu_ready}, 64'd0);
        tick();
        check("sim_n1_rd", {59'd0, rd}, 64'd4);
        check("sim_n1_commit", {63'd0, commit_valid}, 64'd1);
        check("sim_n1_pc", commit_pc, 64'h3000);
        lsu_valid = 0;
        #1;
        check("sim_exu_ready_n1", {63'd0, exu_ready}, 64'd1);
        tick();
        check("sim_n2_rd", {59'd0, rd}, 64'd3);
        check("sim_n2_x_rd", x_rd, 64'h33);
        check("sim_n2_commit", {63'd0, commit_valid}, 64'd1);
        idle_inputs();
        tick();
        check("idle_commit", {63'd0, commit_valid}, 64'd0);
        check("idle_wen", {63'd0, rd_w_en}, 64'd0);

        drive_exu(5'd0, 1'b1, 64'hABCD, 64'h4000);
        tick();
        check("rd0_wen", {63'd0, rd_w_en}, 64'd0);
        check("rd0_commit", {63'd0, commit_valid}, 64'd1);
        idle_inputs();
        drive_lsu(5'd7, 1'b0, 3'b011, 3'd0, 64'h5000);
        tick();
        check("store_wen", {63'd0, rd_w_en}, 64'd0);
        check("store_commit", {63'd0, commit_valid}, 64'd1);

        // Asynchronous reset while an entry is held.
        idle_inputs();
        drive_exu(5'd9, 1'b1, 64'h99, 64'h6000);
        tick();
        check("pre_rst_commit", {63'd0, commit_valid}, 64'd1);
        idle_inputs();
        #1;
        rst = 0;
        #1;
        check("arst_commit", {63'd0, commit_valid}, 64'd0);
        check("arst_wen", {63'd0, rd_w_en}, 64'd0);
        check("arst_x_rd", x_rd, 64'd0);
        check("arst_pc", commit_pc, 64'd0);
        check("arst_instret", instret, 64'd0);
        check("arst_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        @(negedge clk);
        rst = 1;
        tick();
        check("post_rst_commit", {63'd0, commit_valid}, 64'd0);

        // Ten back-to-back EXU retires.
        for (int i = 0; i < 10; i++) begin
            drive_exu(5'(i + 1), 1'b1, 64'(i * 16 + 7), 64'h8000_0000 + 64'(i * 4));
            tick();
            check("b2b_commit", {63'd0, commit_valid}, 64'd1);
            check("b2b_x_rd", x_rd, 64'(i * 16 + 7));
            check("b2b_pc", commit_pc, 64'h8000_0000 + 64'(i * 4));
        end
        idle_inputs();
        tick();
        check("b2b_done_commit", {63'd0, commit_valid}, 64'd0);
`ifdef WBU_INSTRET_EN
        exp_cnt = 64'd10;
`else
        exp_cnt = 64'd0;
`endif
        check("instret_10", instret, exp_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
